// File: rtl/rx_frame_parser.sv
// Frame parser between the UART receive FIFO and the Viterbi decoder input.
// It hunts for sync, checks LEN and CHK, and streams the payload out as 2-bit symbols, MSB pair first.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_HUNT   | pop bytes, drop everything except SYNC_BYTE
// S_LEN    | pop LEN, reject 0 or > MAX_LEN, else arm counters
// S_PAY_RD | pop one payload byte into the shift register
// S_EMIT   | present shift[7:6], shift on each accept, 4 symbols/byte
// S_CHK    | pop CHK, compare with accumulator, report done/err
module rx_frame_parser #(
  parameter int          SIZE_DATA = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          MAX_LEN   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  output logic [1:0]           o_sym,
  output logic                 o_sym_valid,
  input  logic                 i_sym_ready,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_LEN    = 3'd1,
    S_PAY_RD = 3'd2,
    S_EMIT   = 3'd3,
    S_CHK    = 3'd4
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic       rd_pend_q, rd_pend_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] sym_cnt_q, sym_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] chk_q, chk_d;
  logic       start_q, start_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       rd_en;
  logic [7:0] byte_in;

  assign byte_in = i_fifo_data;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    sym_cnt_d  = sym_cnt_q;
    byte_cnt_d = byte_cnt_q;
    chk_d      = chk_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // Every state except S_EMIT consumes bytes; only one pop may be in flight.
    rd_en      = (state_q != S_EMIT) && !i_fifo_empty && !rd_pend_q;

    case (state_q)
      S_HUNT: begin
        if (rd_pend_q && (byte_in == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rd_pend_q) begin
          if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            byte_cnt_d = byte_in;
            chk_d      = byte_in;
            start_d    = 1'b1;
            state_d    = S_PAY_RD;
          end
        end
      end
      S_PAY_RD: begin
        if (rd_pend_q) begin
          chk_d     = chk_q ^ byte_in;
          shift_d   = byte_in;
          sym_cnt_d = 2'd0;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (i_sym_ready) begin
          shift_d   = {shift_q[5:0], 2'b00};
          sym_cnt_d = sym_cnt_q + 2'd1;
          if (sym_cnt_q == 2'd3) begin
            byte_cnt_d = byte_cnt_q - 8'd1;
            state_d    = (byte_cnt_q == 8'd1) ? S_CHK : S_PAY_RD;
          end
        end
      end
      S_CHK: begin
        if (rd_pend_q) begin
          done_d  = 1'b1;
          err_d   = (byte_in != chk_q);
          state_d = S_HUNT;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    // Abort wins over everything; a pop already in flight is simply forgotten.
    if (i_clear) begin
      state_d = S_HUNT;
      rd_en   = 1'b0;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    rd_pend_d = rd_en;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_HUNT;
      rd_pend_q  <= 1'b0;
      shift_q    <= 8'd0;
      sym_cnt_q  <= 2'd0;
      byte_cnt_q <= 8'd0;
      chk_q      <= 8'd0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      shift_q    <= shift_d;
      sym_cnt_q  <= sym_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      chk_q      <= chk_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_fifo_rd_en  = rd_en;
  assign o_sym         = shift_q[7:6];
  assign o_sym_valid   = (state_q == S_EMIT);
  assign o_frame_start = start_q;
  assign o_frame_done  = done_q;
  assign o_frame_err   = err_q;
  assign o_busy        = (state_q != S_HUNT);

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: a table of frames plus hand sequences for
// symbol stall, abort, mid-frame reset and the maximum frame length.
module tb_rx_frame_parser;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_clear;
  logic       i_fifo_empty;
  logic [7:0] i_fifo_data;
  logic       o_fifo_rd_en;
  logic [1:0] o_sym;
  logic       o_sym_valid;
  logic       i_sym_ready;
  logic       o_frame_start;
  logic       o_frame_done;
  logic       o_frame_err;
  logic       o_busy;

  rx_frame_parser #(.SIZE_DATA(8), .SYNC_BYTE(8'hA5), .MAX_LEN(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
    .o_fifo_rd_en(o_fifo_rd_en), .o_sym(o_sym), .o_sym_valid(o_sym_valid),
    .i_sym_ready(i_sym_ready), .o_frame_start(o_frame_start),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // FIFO model: bytes appended by the stimulus, popped with one cycle latency.
  logic [7:0] src [0:255];
  int src_len = 0;
  int rd_ptr = 0;
  int pop_empty = 0;
  assign i_fifo_empty = (rd_ptr >= src_len);

  always @(posedge i_clk) begin
    if (o_fifo_rd_en) begin
      if (rd_ptr >= src_len) pop_empty <= pop_empty + 1;
      else begin
        i_fifo_data <= src[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Output recorder, sampled mid-cycle.
  logic [1:0] sym_log[$];
  int start_cnt = 0, done_cnt = 0, derr_cnt = 0, ealone_cnt = 0;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_sym_valid && i_sym_ready) sym_log.push_back(o_sym);
      if (o_frame_start) start_cnt <= start_cnt + 1;
      if (o_frame_done) begin
        done_cnt <= done_cnt + 1;
        if (o_frame_err) derr_cnt <= derr_cnt + 1;
      end else if (o_frame_err) ealone_cnt <= ealone_cnt + 1;
    end
  end

  int total = 0;
  int bad = 0;
  int s_base, s_start, s_done, s_derr, s_ealone;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    src[src_len] = b;
    src_len++;
  endtask

  task automatic snap();
    s_base = sym_log.size();
    s_start = start_cnt; s_done = done_cnt; s_derr = derr_cnt; s_ealone = ealone_cnt;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 3000; c++) begin
      if ((rd_ptr == src_len) && !o_busy) break;
      tick();
    end
    if (c >= 3000) cmp({name, "_timeout"}, 1, 0);
    repeat (4) tick();
  endtask

  task automatic wait_syms(input string name, input int n);
    int c;
    for (c = 0; c < 3000; c++) begin
      if (sym_log.size() >= n) break;
      tick();
    end
    if (c >= 3000) cmp({name, "_timeout"}, 1, 0);
  endtask

  task automatic check_counts(input string nm, input int st, input int dn, input int de, input int ea);
    cmp({nm, "_start"}, start_cnt - s_start, st);
    cmp({nm, "_done"}, done_cnt - s_done, dn);
    cmp({nm, "_done_err"}, derr_cnt - s_derr, de);
    cmp({nm, "_err_alone"}, ealone_cnt - s_ealone, ea);
  endtask

  typedef struct packed {
    logic [63:0] bytes;
    int nb;
    logic [15:0] syms;
    int ns;
    int starts;
    int dones;
    int derrs;
    int ealone;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vec_t v;
    logic [15:0] act;
    logic [7:0] b, xr;
    int mism;
    string nm;

    vecs[0] = '{bytes:64'hA5021BE4FD000000, nb:5, syms:16'h1BE4, ns:8, starts:1, dones:1, derrs:0, ealone:0};
    vecs[1] = '{bytes:64'hA501FF0000000000, nb:4, syms:16'hFF00, ns:4, starts:1, dones:1, derrs:1, ealone:0};
    vecs[2] = '{bytes:64'h3C5AA50180810000, nb:6, syms:16'h8000, ns:4, starts:1, dones:1, derrs:0, ealone:0};
    vecs[3] = '{bytes:64'hA500000000000000, nb:2, syms:16'h0000, ns:0, starts:0, dones:0, derrs:0, ealone:1};
    vecs[4] = '{bytes:64'hA541000000000000, nb:2, syms:16'h0000, ns:0, starts:0, dones:0, derrs:0, ealone:1};
    vecs[5] = '{bytes:64'hA501A5A400000000, nb:4, syms:16'hA500, ns:4, starts:1, dones:1, derrs:0, ealone:0};

    i_rst_n = 1'b0;
    i_clear = 1'b0;
    i_sym_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    cmp("rst_rd_en", int'(o_fifo_rd_en), 0);
    cmp("rst_sym_valid", int'(o_sym_valid), 0);
    cmp("rst_sym", int'(o_sym), 0);
    cmp("rst_pulses", int'({o_frame_start, o_frame_done, o_frame_err}), 0);
    cmp("rst_busy", int'(o_busy), 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      nm = $sformatf("vec%0d", i);
      snap();
      for (int k = 0; k < v.nb; k++) push(v.bytes[63-8*k -: 8]);
      wait_idle(nm);
      check_counts(nm, v.starts, v.dones, v.derrs, v.ealone);
      cmp({nm, "_nsyms"}, sym_log.size() - s_base, v.ns);
      act = 16'h0;
      for (int k = 0; k < 8 && (s_base + k) < sym_log.size(); k++) act[15-2*k -: 2] = sym_log[s_base+k];
      cmp({nm, "_syms"}, int'(act), int'(v.syms));
      cmp({nm, "_busy_after"}, int'(o_busy), 0);
    end

    // Decoder stalls for 5 cycles while the second symbol is presented.
    snap();
    push(8'hA5); push(8'h02); push(8'h1B); push(8'hE4); push(8'hFD);
    wait_syms("stall_first", s_base + 1);
    i_sym_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      cmp($sformatf("stall_valid%0d", c), int'(o_sym_valid), 1);
      cmp($sformatf("stall_sym%0d", c), int'(o_sym), 1);
    end
    tick();
    i_sym_ready = 1'b1;
    wait_idle("stall");
    check_counts("stall", 1, 1, 0, 0);
    act = 16'h0;
    for (int k = 0; k < 8 && (s_base + k) < sym_log.size(); k++) act[15-2*k -: 2] = sym_log[s_base+k];
    cmp("stall_nsyms", sym_log.size() - s_base, 8);
    cmp("stall_syms", int'(act), 16'h1BE4);

    // Abort while the second payload byte (a sync value) is in flight.
    for (int pass = 0; pass < 2; pass++) begin
      nm = (pass == 0) ? "clear" : "arst";
      snap();
      push(8'hA5); push(8'h02); push(8'h1B); push(8'hA5); push(8'hBC);
      wait_syms(nm, s_base + 4);
      tick();
      if (pass == 0) i_clear = 1'b1;
      else i_rst_n = 1'b0;
      if (pass == 0) tick();
      @(negedge i_clk);
      cmp({nm, "_valid"}, int'(o_sym_valid), 0);
      cmp({nm, "_busy"}, int'(o_busy), 0);
      cmp({nm, "_pulses"}, int'({o_frame_start, o_frame_done, o_frame_err}), 0);
      tick();
      i_clear = 1'b0;
      i_rst_n = 1'b1;
      wait_idle(nm);
      check_counts({nm, "_abort"}, 1, 0, 0, 0);
      cmp({nm, "_abort_nsyms"}, sym_log.size() - s_base, 4);
      snap();
      push(8'hA5); push(8'h01); push(8'h80); push(8'h81);
      wait_idle({nm, "_next"});
      check_counts({nm, "_next"}, 1, 1, 0, 0);
      act = 16'h0;
      for (int k = 0; k < 8 && (s_base + k) < sym_log.size(); k++) act[15-2*k -: 2] = sym_log[s_base+k];
      cmp({nm, "_next_nsyms"}, sym_log.size() - s_base, 4);
      cmp({nm, "_next_syms"}, int'(act), 16'h8000);
    end

    // Longest legal frame.
    snap();
    push(8'hA5); push(8'h40);
    xr = 8'h40;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i * 7 + 3);
      push(b);
      xr = xr ^ b;
    end
    push(xr);
    wait_idle("maxlen");
    check_counts("maxlen", 1, 1, 0, 0);
    cmp("maxlen_nsyms", sym_log.size() - s_base, 256);
    mism = 0;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i * 7 + 3);
      for (int j = 0; j < 4; j++)
        if ((s_base + 4*i + j) < sym_log.size() && sym_log[s_base+4*i+j] != b[7-2*j -: 2]) mism++;
    end
    cmp("maxlen_sym_mismatches", mism, 0);

    cmp("pop_while_empty", pop_empty, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_parser.md
Name: rx_frame_parser

Overview:
- Downstream consumer of the UART receive path. Pops received bytes from the receiver FIFO read port and hunts for a frame sync byte.
- Validates a length/checksum framed packet and streams the payload to the Viterbi decoder input as 2-bit hard-decision symbols over a valid/ready handshake.
- Reports frame start, frame completion and frame error per packet.

Parameters:
- SIZE_DATA, 8, byte width of the FIFO read data. The block supports only 8.
- SYNC_BYTE, 8'hA5, frame sync pattern.
- MAX_LEN, 64, maximum payload length in bytes (1..255).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous abort; returns the block to sync hunt.
- i_fifo_empty  input  1  receiver FIFO empty flag.
- i_fifo_data  input  SIZE_DATA  FIFO read data; valid the cycle after o_fifo_rd_en.
- o_fifo_rd_en  output  1  one-cycle FIFO pop request.
- o_sym  output  2  symbol pair to the decoder.
- o_sym_valid  output  1  o_sym valid.
- i_sym_ready  input  1  decoder accepts the symbol.
- o_frame_start  output  1  one-cycle pulse when a valid LEN is accepted.
- o_frame_done  output  1  one-cycle pulse after CHK is evaluated.
- o_frame_err  output  1  qualifies o_frame_done, or pulses alone on a bad LEN.
- o_busy  output  1  high in every state except S_HUNT.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state S_HUNT; shift register, counters and checksum accumulator 0.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
  - CHK = XOR of LEN and all payload bytes.
- FIFO read handshake:
  - o_fifo_rd_en is asserted for exactly one cycle when the state needs a byte, !i_fifo_empty, and no read is outstanding.
  - The data is sampled the following cycle (read latency 1).
  - Never more than one read is outstanding. No pop ever occurs while i_fifo_empty=1.
- States:
  - S_HUNT: read bytes; discard every byte that is not SYNC_BYTE. On SYNC_BYTE go to S_LEN.
  - S_LEN: read LEN.
    - LEN==0 or LEN>MAX_LEN: pulse o_frame_err (o_frame_done stays 0), return to S_HUNT.
    - Otherwise: load byte counter = LEN, checksum = LEN, pulse o_frame_start, go to S_PAY_RD.
  - S_PAY_RD: read a payload byte, XOR it into the checksum, load the 8-bit shift register, set symbol counter=0, go to S_EMIT.
  - S_EMIT:
    - o_sym = shift[7:6], o_sym_valid=1.
    - On valid&&ready: shift left by 2 and increment the symbol counter.
    - After the 4th accept, decrement the byte counter. Go to S_PAY_RD if it is nonzero, else S_CHK.
    - Symbol order is MSB pair first.
    - o_sym and o_sym_valid stay stable while i_sym_ready=0.
    - The first symbol appears 1 cycle after the data-sample cycle (registered output).
  - S_CHK: read CHK.
    - Pulse o_frame_done the cycle after sampling.
    - o_frame_err = (CHK != accumulator) in the same cycle.
    - Return to S_HUNT.
- Payload symbols are forwarded before the check completes. The decoder discards the frame on o_frame_done&&o_frame_err.
- i_clear has priority over all transitions:
  - Next cycle: state S_HUNT, o_sym_valid=0, no pulses.
  - An outstanding read's data is dropped, not reinterpreted as sync.
- An asynchronous reset mid-frame behaves identically to power-on; the partial frame is lost.
- Symbol back-to-back rate: 1 symbol/cycle while ready=1. A per-byte gap of ≥2 cycles is allowed for the read.
- Sync inside the payload is treated as data. There is no resync until S_HUNT.

Test Plan:
- FIFO holds A5 02 1B E4 FD, ready=1 → o_frame_start once; symbols 0,1,2,3,3,2,1,0; o_frame_done=1, o_frame_err=0; o_busy=0 after.
- A5 01 FF 00 → symbols 3,3,3,3; o_frame_done=1 with o_frame_err=1 (expected CHK FE).
- 3C 5A A5 01 80 81 → 3C and 5A are popped and dropped; symbols 2,0,0,0; done with err=0.
- A5 00, then A5 41 (MAX_LEN=64) → each gives an o_frame_err pulse, no o_frame_start, no symbols; returns to hunt.
- Frame A5 02 1B E4 FD with i_sym_ready=0 for 5 cycles at the 2nd symbol → o_sym=1 and valid held all 5 cycles; the sequence completes unchanged.
- i_clear, or i_rst_n low, asserted during the 2nd payload byte → next cycle o_sym_valid=0, o_busy=0. A following good frame decodes correctly.
